controller_modulo: RTL and testbench

Control unit placed directly upstream of `datapath_modulo`: it drives every write-back flag, register-transfer select and ALU mode of the datapath to compute `Zahl1 mod Zahl2` by repeated compare/subtract. It consumes the datapath's `valid_o` as its loop-termination feedback. It reports `busy_o`, `done_o` and `err_o` to the host.

---
 rtl/controller_modulo_if.sv | 26 ++
 rtl/controller_modulo.sv | 140 ++++++++++++++
 tb/tb_controller_modulo.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/controller_modulo_if.sv
// Control/feedback bundle between controller_modulo (master) and datapath_modulo (slave).
interface controller_modulo_if;
  logic [2:0] alu_mode_o;
  logic       wren_update_Zahlen;
  logic       wren_Zahl1_to_erg;
  logic       wren_term_erg;
  logic       wren_res_to_erg;
  logic       erg_to_alu_a;
  logic       Zahl2_to_alu_b;
  logic       check_for_termination_o;
  logic       valid_i;

  // Control flags are level signals, valid every cycle; valid_i is only
  // meaningful while check_for_termination_o is high (no ready/backpressure).
  modport master (
    output alu_mode_o, wren_update_Zahlen, wren_Zahl1_to_erg, wren_term_erg,
    output wren_res_to_erg, erg_to_alu_a, Zahl2_to_alu_b, check_for_termination_o,
    input  valid_i
  );

  modport slave (
    input  alu_mode_o, wren_update_Zahlen, wren_Zahl1_to_erg, wren_term_erg,
    input  wren_res_to_erg, erg_to_alu_a, Zahl2_to_alu_b, check_for_termination_o,
    output valid_i
  );
endinterface

// File: rtl/controller_modulo.sv
// Sequencer computing Zahl1 mod Zahl2 on datapath_modulo by repeated compare/subtract.
module controller_modulo #(
  parameter int unsigned ALU_LAT  = 2,
  parameter logic [15:0] MAX_ITER = 16'hFFFF,
  parameter logic [2:0]  MODE_SUB = 3'd1,
  parameter logic [2:0]  MODE_LT  = 3'd2
) (
  input  logic                clk,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [15:0]         Zahl1_i,
  input  logic [15:0]         Zahl2_i,
  controller_modulo_if.master dp,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [3:0]          state_dbg_o
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LOAD   = 4'd1;
  localparam logic [3:0] S_INIT   = 4'd2;
  localparam logic [3:0] S_CMP    = 4'd3;
  localparam logic [3:0] S_CMP_WB = 4'd4;
  localparam logic [3:0] S_CHECK  = 4'd5;
  localparam logic [3:0] S_SUB    = 4'd6;
  localparam logic [3:0] S_SUB_WB = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;
  localparam logic [3:0] S_ERR    = 4'd9;

  localparam logic [3:0] WAIT_INIT = 4'(ALU_LAT - 1);

  logic [3:0]  state, state_nxt;
  logic [3:0]  wait_cnt;
  logic [15:0] iter_cnt, iter_inc;
  logic        operand_bad;
  logic        wait_load;

  logic [2:0]  alu_mode_nxt;
  logic        upd_nxt, z1_erg_nxt, term_nxt, res_nxt, sel_nxt, check_nxt;
  logic        busy_nxt, done_nxt, err_nxt;

  // Compare on full vectors so every input bit participates in the range check.
  assign operand_bad = (Zahl2_i == 16'd0) || (Zahl2_i > 16'h7FFF) || (Zahl1_i > 16'h7FFF);
  assign iter_inc    = iter_cnt + 16'd1;
  assign wait_load   = ((state_nxt == S_CMP) && (state != S_CMP)) ||
                       ((state_nxt == S_SUB) && (state != S_SUB));
  assign state_dbg_o = state;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start_i) state_nxt = operand_bad ? S_ERR : S_LOAD;
      S_LOAD:   state_nxt = S_INIT;
      S_INIT:   state_nxt = S_CMP;
      S_CMP:    if (wait_cnt == 4'd0) state_nxt = S_CMP_WB;
      S_CMP_WB: state_nxt = S_CHECK;
      S_CHECK:  state_nxt = dp.valid_i ? S_DONE : S_SUB;
      S_SUB:    if (wait_cnt == 4'd0) state_nxt = S_SUB_WB;
      S_SUB_WB: state_nxt = (iter_inc == MAX_ITER) ? S_ERR : S_CMP;
      S_DONE:   state_nxt = S_IDLE;
      S_ERR:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up
  // with the state register and stay glitch-free toward the datapath.
  always_comb begin
    alu_mode_nxt = 3'd0;
    upd_nxt      = 1'b0;
    z1_erg_nxt   = 1'b0;
    term_nxt     = 1'b0;
    res_nxt      = 1'b0;
    sel_nxt      = 1'b0;
    check_nxt    = 1'b0;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    busy_nxt     = (state_nxt != S_IDLE);
    case (state_nxt)
      S_LOAD:   upd_nxt = 1'b1;
      S_INIT:   z1_erg_nxt = 1'b1;
      S_CMP:    begin alu_mode_nxt = MODE_LT;  sel_nxt = 1'b1; end
      S_CMP_WB: begin alu_mode_nxt = MODE_LT;  sel_nxt = 1'b1; term_nxt = 1'b1; end
      S_CHECK:  check_nxt = 1'b1;
      S_SUB:    begin alu_mode_nxt = MODE_SUB; sel_nxt = 1'b1; end
      S_SUB_WB: begin alu_mode_nxt = MODE_SUB; sel_nxt = 1'b1; res_nxt = 1'b1; end
      S_DONE:   done_nxt = 1'b1;
      S_ERR:    err_nxt = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state                      <= S_IDLE;
      wait_cnt                   <= 4'd0;
      iter_cnt                   <= 16'd0;
      dp.alu_mode_o              <= 3'd0;
      dp.wren_update_Zahlen      <= 1'b0;
      dp.wren_Zahl1_to_erg       <= 1'b0;
      dp.wren_term_erg           <= 1'b0;
      dp.wren_res_to_erg         <= 1'b0;
      dp.erg_to_alu_a            <= 1'b0;
      dp.Zahl2_to_alu_b          <= 1'b0;
      dp.check_for_termination_o <= 1'b0;
      busy_o                     <= 1'b0;
      done_o                     <= 1'b0;
      err_o                      <= 1'b0;
    end else begin
      state <= state_nxt;

      if (wait_load) begin
        wait_cnt <= WAIT_INIT;
      end else if (wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end

      // Exit to ERR at MAX_ITER keeps the counter from ever wrapping.
      if (state == S_INIT) begin
        iter_cnt <= 16'd0;
      end else if (state == S_SUB_WB) begin
        iter_cnt <= iter_inc;
      end

      dp.alu_mode_o              <= alu_mode_nxt;
      dp.wren_update_Zahlen      <= upd_nxt;
      dp.wren_Zahl1_to_erg       <= z1_erg_nxt;
      dp.wren_term_erg           <= term_nxt;
      dp.wren_res_to_erg         <= res_nxt;
      dp.erg_to_alu_a            <= sel_nxt;
      dp.Zahl2_to_alu_b          <= sel_nxt;
      dp.check_for_termination_o <= check_nxt;
      busy_o                     <= busy_nxt;
      done_o                     <= done_nxt;
      err_o                      <= err_nxt;
    end
  end

endmodule

// File: tb/tb_controller_modulo.sv
// Bench for controller_modulo with a behavioural datapath_modulo and an output scoreboard.
module tb_controller_modulo;
  localparam int         L      = 2;
  localparam logic [2:0] M_SUB  = 3'd1;
  localparam logic [2:0] M_LT   = 3'd2;
  localparam logic [1:0] K_DONE = 2'b10;
  localparam logic [1:0] K_ERR  = 2'b01;
  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_SUB  = 4'd6;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  logic        start_i  = 1'b0;
  logic        start_wd = 1'b0;
  logic [15:0] zahl1    = 16'd0;
  logic [15:0] zahl2    = 16'd0;
  logic        busy, done, err, busy_wd, done_wd, err_wd;
  logic [3:0]  st, st_wd;
  logic [31:0] cyc = 32'd0;
  int          total = 0;
  int          bad   = 0;

  controller_modulo_if dp_if ();
  controller_modulo_if wd_if ();

  controller_modulo #(.ALU_LAT(L)) dut (
    .clk(clk), .rst_i(rst_i), .start_i(start_i), .Zahl1_i(zahl1), .Zahl2_i(zahl2),
    .dp(dp_if), .busy_o(busy), .done_o(done), .err_o(err), .state_dbg_o(st)
  );

  controller_modulo #(.ALU_LAT(L), .MAX_ITER(16'd4)) u_wd (
    .clk(clk), .rst_i(rst_i), .start_i(start_wd), .Zahl1_i(zahl1), .Zahl2_i(zahl2),
    .dp(wd_if), .busy_o(busy_wd), .done_o(done_wd), .err_o(err_wd), .state_dbg_o(st_wd)
  );

  always @(posedge clk) cyc <= cyc + 32'd1;

  // behavioural datapath: L-stage ALU pipeline in front of wbb
  logic [15:0] z1_r, z2_r, erg, alu_a, alu_b, alu_y;
  logic        term_r;
  logic [15:0] pipe [L];

  always_comb begin
    alu_a = dp_if.erg_to_alu_a   ? erg  : 16'd0;
    alu_b = dp_if.Zahl2_to_alu_b ? z2_r : 16'd0;
    case (dp_if.alu_mode_o)
      M_SUB:   alu_y = alu_a - alu_b;
      M_LT:    alu_y = {15'd0, alu_a < alu_b};
      default: alu_y = 16'd0;
    endcase
  end

  always @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      z1_r <= 16'd0; z2_r <= 16'd0; erg <= 16'd0; term_r <= 1'b0;
      for (int i = 0; i < L; i++) pipe[i] <= 16'd0;
    end else begin
      pipe[0] <= alu_y;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      if (dp_if.wren_update_Zahlen) begin z1_r <= zahl1; z2_r <= zahl2; end
      if (dp_if.wren_Zahl1_to_erg) erg <= z1_r;
      if (dp_if.wren_res_to_erg)   erg <= pipe[L-1];
      if (dp_if.wren_term_erg)     term_r <= pipe[L-1][0];
    end
  end

  assign dp_if.valid_i = dp_if.check_for_termination_o & term_r;
  assign wd_if.valid_i = 1'b0;

  logic [12:0] outs_vec;
  assign outs_vec = {dp_if.alu_mode_o, dp_if.wren_update_Zahlen, dp_if.wren_Zahl1_to_erg,
                     dp_if.wren_term_erg, dp_if.wren_res_to_erg, dp_if.erg_to_alu_a,
                     dp_if.Zahl2_to_alu_b, dp_if.check_for_termination_o, busy, done, err};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // scoreboard: {kind, absolute cycle, ergebnis}
  logic [49:0] exp_q[$];
  int n_upd = 0, n_res = 0, n_res_wd = 0, n_err_wd = 0, n_done_wd = 0;

  always @(negedge clk) begin
    if (dp_if.wren_update_Zahlen) n_upd++;
    if (dp_if.wren_res_to_erg)    n_res++;
    if (wd_if.wren_res_to_erg)    n_res_wd++;
    if (err_wd)                   n_err_wd++;
    if (done_wd)                  n_done_wd++;
  end

  always @(negedge clk) begin
    logic [49:0] e;
    if (!rst_i && (done || err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", {30'd0, done, err}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_kind", {30'd0, done, err}, {30'd0, e[49:48]});
        check("out_cycle", cyc, e[47:16]);
        if (e[49:48] == K_DONE) check("ergebnis", {16'd0, erg}, {16'd0, e[15:0]});
      end
    end
  end

  // driver tasks
  task automatic launch(input logic [15:0] z1, input logic [15:0] z2, output int d);
    int q;
    @(posedge clk); #1;
    zahl1 = z1; zahl2 = z2; start_i = 1'b1;
    if (z2 == 16'd0 || z2[15] || z1[15]) begin
      d = 1;
      exp_q.push_back({K_ERR, cyc + 32'd1, 16'd0});
    end else begin
      q = int'(z1 / z2);
      d = 3 + (q + 1) * (L + 2) + q * (L + 1);
      exp_q.push_back({K_DONE, cyc + 32'(d), z1 % z2});
    end
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic run_op(input logic [15:0] z1, input logic [15:0] z2);
    int d, nb;
    logic bad_op;
    bad_op = (z2 == 16'd0) || z2[15] || z1[15];
    n_upd = 0; n_res = 0;
    launch(z1, z2, d);
    nb = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy) break;
      nb++;
    end
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("busy_cycles", nb, d);
    check("queue_empty", exp_q.size(), 0);
    if (bad_op) begin
      check("upd_on_err", n_upd, 0);
      check("sub_on_err", n_res, 0);
    end else begin
      check("upd_cnt", n_upd, 1);
      check("sub_cnt", n_res, int'(z1 / z2));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    int d1;
    logic [31:0] c0;
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outs", {19'd0, outs_vec}, 32'd0);
    check("rst_state", {28'd0, st}, {28'd0, ST_IDLE});
    #1 rst_i = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // directed runs
    run_op(16'd17, 16'd5);
    run_op(16'd20, 16'd5);
    run_op(16'd3, 16'd7);
    run_op(16'd0, 16'd5);
    run_op(16'd5, 16'd0);
    run_op(16'h8001, 16'd3);
    run_op(16'd10, 16'h8000);
    run_op(16'd12, 16'd1);

    // random runs
    for (int i = 0; i < 4; i++) run_op(16'($urandom_range(0, 60)), 16'($urandom_range(1, 9)));

    // asynchronous reset in SUB
    launch(16'd17, 16'd5, d1);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (st == ST_SUB) break;
    end
    check("reach_sub", {28'd0, st}, {28'd0, ST_SUB});
    #2 rst_i = 1'b1;
    exp_q.delete();
    #1;
    check("async_rst_outs", {19'd0, outs_vec}, 32'd0);
    @(negedge clk); #1 rst_i = 1'b0;
    @(posedge clk); #1;
    check("post_rst_state", {28'd0, st}, {28'd0, ST_IDLE});
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);

    // start held high: second run begins in the IDLE cycle after DONE
    n_upd = 0;
    @(posedge clk); #1;
    zahl1 = 16'd9; zahl2 = 16'd4; start_i = 1'b1;
    c0 = cyc;
    d1 = 3 + 3 * (L + 2) + 2 * (L + 1);
    exp_q.push_back({K_DONE, c0 + 32'(d1), 16'd1});
    exp_q.push_back({K_DONE, c0 + 32'(2 * d1 + 1), 16'd1});
    repeat (d1 + 2) @(posedge clk);
    #1 start_i = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("b2b_idle", {31'd0, busy}, 32'd0);
    check("b2b_queue_empty", exp_q.size(), 0);
    check("b2b_upd_cnt", n_upd, 2);

    // watchdog instance
    @(posedge clk); #1;
    zahl1 = 16'd100; zahl2 = 16'd3; start_wd = 1'b1;
    @(posedge clk); #1 start_wd = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy_wd) break;
    end
    check("wd_idle", {31'd0, busy_wd}, 32'd0);
    check("wd_err_cnt", n_err_wd, 1);
    check("wd_done_cnt", n_done_wd, 0);
    check("wd_sub_cnt", n_res_wd, 4);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
